dm_stage: RTL and testbench

//   M-stage data memory unit of the 5-stage MIPS pipeline. Sits between the E/M and M/W

---
 rtl/dm_stage.sv | 68 ++++++
 tb/tb_dm_stage.sv | 72 +++++++
 2 files changed

// File: rtl/dm_stage.sv
// dm_stage: M-stage data memory with byte/half/word access, extension and address exceptions
module dm_stage #(
  parameter int DEPTH_WORDS = 3072,
  parameter int IDX_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_M,
  input  logic [31:0] PC_M,
  input  logic [31:0] AO_M,
  input  logic [31:0] WD_M,
  input  logic        ov_M,
  input  logic        flush,
  output logic [31:0] DM,
  output logic        exc_req,
  output logic [4:0]  exc_code
);
  logic [31:0] ram [DEPTH_WORDS];
  logic [5:0] op;
  logic is_lw, is_lh, is_lhu, is_lb, is_lbu, is_sw, is_sh, is_sb, is_ld, is_st, misalign, oob, we;
  logic [IDX_W-1:0] idx;
  logic [4:0] sh_amt;
  logic [31:0] word, bmask, wdata;
  logic [15:0] half;
  logic [7:0] byte_v;
  logic unused_ok;
  assign unused_ok = ^{PC_M, IR_M[25:0]};
  assign op = IR_M[31:26];
  assign is_lw = op == 6'b100011;
  assign is_lh = op == 6'b100001;
  assign is_lhu = op == 6'b100101;
  assign is_lb = op == 6'b100000;
  assign is_lbu = op == 6'b100100;
  assign is_sw = op == 6'b101011;
  assign is_sh = op == 6'b101001;
  assign is_sb = op == 6'b101000;
  assign is_ld = is_lw | is_lh | is_lhu | is_lb | is_lbu;
  assign is_st = is_sw | is_sh | is_sb;
  assign misalign = ((is_lw | is_sw) && AO_M[1:0] != 2'b00) || ((is_lh | is_lhu | is_sh) && AO_M[0]);
  assign oob = AO_M >= 32'(4 * DEPTH_WORDS);
  assign exc_req = (is_ld | is_st) && (misalign || oob || ov_M);
  assign exc_code = !exc_req ? 5'd0 : is_ld ? 5'd4 : 5'd5;
  assign idx = AO_M[IDX_W+1:2];
  assign word = (32'(idx) < 32'(DEPTH_WORDS)) ? ram[idx] : 32'd0;
  assign sh_amt = {AO_M[1:0], 3'b000};
  assign half = AO_M[1] ? word[31:16] : word[15:0];
  assign byte_v = 8'(word >> sh_amt);
  assign bmask = 32'hFF << sh_amt;
  always_comb begin
    DM = exc_req ? 32'd0
       : is_lw  ? word
       : is_lh  ? {{16{half[15]}}, half}
       : is_lhu ? {16'd0, half}
       : is_lb  ? {{24{byte_v[7]}}, byte_v}
       : is_lbu ? {24'd0, byte_v}
       : 32'd0;
    wdata = is_sw ? WD_M
          : is_sh ? (AO_M[1] ? {WD_M[15:0], word[15:0]} : {word[31:16], WD_M[15:0]})
          : (word & ~bmask) | ({24'd0, WD_M[7:0]} << sh_amt);
  end
  assign we = is_st && !exc_req && !flush;
  // one register process per word keeps the whole-RAM synchronous clear simple
  for (genvar g = 0; g < DEPTH_WORDS; g++) begin : g_word
    always_ff @(posedge clk)
      if (reset) ram[g] <= 32'd0;
      else if (we && idx == IDX_W'(g)) ram[g] <= wdata;
  end
endmodule

// File: tb/tb_dm_stage.sv
// tb_dm_stage: scoreboard bench for dm_stage load/store, extension, exceptions, flush and reset
module tb_dm_stage;
  logic clk = 0, reset, ov_M, flush, exc_req;
  logic [31:0] IR_M, PC_M, AO_M, WD_M, DM;
  logic [4:0] exc_code;
  int checks = 0, failures = 0;
  typedef struct {string tag; logic [31:0] dm; logic exc; logic [4:0] code;} exp_t;
  exp_t sb_q[$];
  localparam logic [5:0] LW = 6'h23, LH = 6'h21, LHU = 6'h25, LB = 6'h20, LBU = 6'h24,
                         SW = 6'h2B, SH = 6'h29, SB = 6'h28, RT = 6'h00;
  dm_stage dut (.clk(clk), .reset(reset), .IR_M(IR_M), .PC_M(PC_M), .AO_M(AO_M), .WD_M(WD_M),
                .ov_M(ov_M), .flush(flush), .DM(DM), .exc_req(exc_req), .exc_code(exc_code));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask
  task automatic step(input string tag, input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                      input logic ov, input logic fl, input logic rs,
                      input logic [31:0] edm, input logic eexc, input logic [4:0] ecode);
    exp_t e;
    IR_M = (op == RT) ? 32'h0043_0821 : {op, 26'h0};
    AO_M = a; WD_M = wd; ov_M = ov; flush = fl; reset = rs; PC_M = PC_M + 4;
    sb_q.push_back('{tag, edm, eexc, ecode});
    @(negedge clk);
    e = sb_q.pop_front();
    check({e.tag, ".dm"}, DM, e.dm);
    check({e.tag, ".exc"}, 32'(exc_req), 32'(e.exc));
    check({e.tag, ".code"}, 32'(exc_code), 32'(e.code));
    @(posedge clk); #1;
  endtask
  initial begin
    PC_M = 32'h3000;
    @(posedge clk); #1;
    step("rst_sw40", SW, 32'h40, 32'hFFFF_FFFF, 0, 0, 1, 0, 0, 0);
    step("lw40", LW, 32'h40, 0, 0, 0, 0, 0, 0, 0);
    step("sw10", SW, 32'h10, 32'h1234_5678, 0, 0, 0, 0, 0, 0);
    step("lw10a", LW, 32'h10, 0, 0, 0, 0, 32'h1234_5678, 0, 0);
    step("sb13", SB, 32'h13, 32'h0000_00AB, 0, 0, 0, 0, 0, 0);
    step("lb13", LB, 32'h13, 0, 0, 0, 0, 32'hFFFF_FFAB, 0, 0);
    step("lbu13", LBU, 32'h13, 0, 0, 0, 0, 32'h0000_00AB, 0, 0);
    step("lw10b", LW, 32'h10, 0, 0, 0, 0, 32'hAB34_5678, 0, 0);
    step("sh12", SH, 32'h12, 32'h0000_8001, 0, 0, 0, 0, 0, 0);
    step("lh12", LH, 32'h12, 0, 0, 0, 0, 32'hFFFF_8001, 0, 0);
    step("lhu12", LHU, 32'h12, 0, 0, 0, 0, 32'h0000_8001, 0, 0);
    step("lw10c", LW, 32'h10, 0, 0, 0, 0, 32'h8001_5678, 0, 0);
    step("lb11", LB, 32'h11, 0, 0, 0, 0, 32'h0000_0056, 0, 0);
    step("lh10", LH, 32'h10, 0, 0, 0, 0, 32'h0000_5678, 0, 0);
    step("sw14", SW, 32'h14, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 0);
    step("sh15", SH, 32'h15, 32'h0000_1111, 0, 0, 0, 0, 1, 5);
    step("lw14", LW, 32'h14, 0, 0, 0, 0, 32'hCAFE_F00D, 0, 0);
    step("lw11", LW, 32'h11, 0, 0, 0, 0, 0, 1, 4);
    step("sw3000", SW, 32'h3000, 32'h5555_5555, 0, 0, 0, 0, 1, 5);
    step("lw3000", LW, 32'h3000, 0, 0, 0, 0, 0, 1, 4);
    step("sw2ffc", SW, 32'h2FFC, 32'h0BAD_BEEF, 0, 0, 0, 0, 0, 0);
    step("lw2ffc", LW, 32'h2FFC, 0, 0, 0, 0, 32'h0BAD_BEEF, 0, 0);
    step("lw0", LW, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    step("sw20fl", SW, 32'h20, 32'h7777_7777, 0, 1, 0, 0, 0, 0);
    step("lw20", LW, 32'h20, 0, 0, 0, 0, 0, 0, 0);
    step("lw10ov", LW, 32'h10, 0, 1, 0, 0, 0, 1, 4);
    step("sb10ov", SB, 32'h10, 32'hFF, 1, 0, 0, 0, 1, 5);
    step("lw10d", LW, 32'h10, 0, 0, 0, 0, 32'h8001_5678, 0, 0);
    step("addu", RT, 32'h11, 0, 1, 0, 0, 0, 0, 0);
    step("rst2", RT, 32'h0, 0, 0, 0, 1, 0, 0, 0);
    step("lw10e", LW, 32'h10, 0, 0, 0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
